// File: rtl/palindrome_pkg.sv
// rtl/palindrome_pkg.sv - shared types and constants for the palindrome scan controller
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } pal_state_e;

  localparam int PAL_WIN = 3;

endpackage

// File: rtl/palindrome_window.sv
// rtl/palindrome_window.sv - serial 3-bit window with fill tracking and palindrome hit
module palindrome_window
  import palindrome_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic hit,
  output logic hit_valid
);

  // The two stored bits plus the incoming bit form the full window; the
  // oldest stored bit is the one compared against the incoming bit.
  logic [PAL_WIN-2:0] hist_q;
  logic [1:0]         fill_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= {hist_q[PAL_WIN-3:0], bit_in};
      if (fill_q != 2'(PAL_WIN - 1)) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end

  assign hit       = (hist_q[PAL_WIN-2] == bit_in);
  assign hit_valid = (fill_q == 2'(PAL_WIN - 1));

endmodule

// File: rtl/palindrome_scan_ctrl.sv
// rtl/palindrome_scan_ctrl.sv - word-level sequencer for the serial palindrome window detector
module palindrome_scan_ctrl
  import palindrome_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(DATA_W - 1),
  localparam int MAP_W = DATA_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  out_count_o,
  output logic [MAP_W-1:0]  out_map_o,
  output logic              busy_o
);

  localparam int K_W = $clog2(DATA_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(DATA_W - 1);

  pal_state_e        state_q, state_d;
  logic [DATA_W-1:0] sreg_q;
  logic [K_W-1:0]    k_q;
  logic [CNT_W-1:0]  count_q;
  logic [MAP_W-1:0]  map_q;
  logic              accept;
  logic              shift_en;
  logic              hit;
  logic              hit_valid;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      k_q     <= '0;
      count_q <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sreg_q  <= in_data_i;
        k_q     <= '0;
        count_q <= '0;
        map_q   <= '0;
      end else if (shift_en) begin
        // MSB streams out first, so bit k of the scan is always sreg_q's top bit
        sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
        k_q    <= k_q + K_W'(1);
        if (hit && hit_valid) begin
          count_q <= count_q + CNT_W'(1);
          map_q   <= map_q | (MAP_W'(1) << (k_q - K_W'(2)));
        end
      end
    end
  end

  palindrome_window u_window (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .shift_en  (shift_en),
    .bit_in    (sreg_q[DATA_W-1]),
    .hit       (hit),
    .hit_valid (hit_valid)
  );

  // Ready is held low for the whole reset pulse, not only after the first edge.
  assign in_ready_o  = (state_q == IDLE) && !reset;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == SHIFT);
  assign out_count_o = count_q;
  assign out_map_o   = map_q;

endmodule
